// File: rtl/can_bus_init_seq_pkg.sv
// Shared types, default timing constants and the bus-index clamp for the
// MOPSHUB per-bus initialisation sequencer.
package mopshub_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SELECT    = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_TRIM_REQ  = 3'd3,
        ST_TRIM_WAIT = 3'd4,
        ST_NEXT      = 3'd5,
        ST_DONE      = 3'd6
    } seq_state_t;

    localparam int SETTLE_CYC_DEF  = 64;
    localparam int TIMEOUT_CYC_DEF = 4096;
    localparam int MAX_RETRY_DEF   = 2;

    function automatic int clamp_bus_idx(input int n, input int max_idx);
        return (n > max_idx) ? max_idx : n;
    endfunction

endpackage

// File: rtl/can_bus_init_seq_timer.sv
// Loadable down-counter with a zero flag; shared by the settle and
// trim-timeout phases of the sequencer.
module seq_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (dec && cnt_q != '0)
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/can_bus_init_seq.sv
// Per-bus power-enable / settle / oscillator-trim sequencer with retry,
// abort and sticky per-bus pass/fail flags. All outputs are registered.
module can_bus_init_seq
    import mopshub_seq_pkg::*;
#(
    parameter int N_BUSES     = 32,
    parameter int BUS_W       = $clog2(N_BUSES),
    parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int MAX_RETRY   = MAX_RETRY_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [BUS_W-1:0]   n_buses,
    input  logic [N_BUSES-1:0] bus_mask,
    input  logic               trim_ack,
    output logic               busy,
    output logic               start_init,
    output logic               end_init,
    output logic               power_bus_en,
    output logic [BUS_W-1:0]   power_bus_cnt,
    output logic               trim_req,
    output logic               end_trim_bus,
    output logic [N_BUSES-1:0] bus_ok,
    output logic [N_BUSES-1:0] bus_fail
);

    localparam int TMAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    seq_state_t         state_q, state_d;
    logic [BUS_W-1:0]   index_q, index_d;
    logic [2:0]         retry_q, retry_d;
    logic [N_BUSES-1:0] bus_ok_q, bus_ok_d, bus_fail_q, bus_fail_d;
    logic               busy_q, busy_d, start_init_q, start_init_d;
    logic               end_init_q, end_init_d, power_q, power_d;
    logic               trim_req_q, trim_req_d, end_trim_q, end_trim_d;

    logic               tmr_load, tmr_dec, tmr_zero;
    logic [TW-1:0]      tmr_val;
    logic [BUS_W-1:0]   last_idx;

    assign last_idx = BUS_W'(clamp_bus_idx(int'(n_buses), N_BUSES - 1));

    seq_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        retry_d      = retry_q;
        bus_ok_d     = bus_ok_q;
        bus_fail_d   = bus_fail_q;
        power_d      = power_q;
        start_init_d = 1'b0;
        end_init_d   = 1'b0;
        trim_req_d   = 1'b0;
        end_trim_d   = 1'b0;
        tmr_load     = 1'b0;
        tmr_val      = '0;
        tmr_dec      = 1'b0;

        // abort outranks start and trim_ack; partial results are kept
        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            power_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (start && !abort) begin
                    state_d      = ST_SELECT;
                    start_init_d = 1'b1;
                    bus_ok_d     = '0;
                    bus_fail_d   = '0;
                    index_d      = '0;
                end
                ST_SELECT: if (!bus_mask[index_q]) begin
                    state_d = ST_NEXT;
                end else begin
                    power_d  = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(SETTLE_CYC - 1);
                    retry_d  = '0;
                    state_d  = ST_SETTLE;
                end
                ST_SETTLE: if (tmr_zero) begin
                    state_d    = ST_TRIM_REQ;
                    trim_req_d = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
                ST_TRIM_REQ: begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(TIMEOUT_CYC - 1);
                    state_d  = ST_TRIM_WAIT;
                end
                ST_TRIM_WAIT: if (trim_ack) begin
                    bus_ok_d[index_q] = 1'b1;
                    end_trim_d        = 1'b1;
                    power_d           = 1'b0;
                    state_d           = ST_NEXT;
                end else if (tmr_zero) begin
                    if (retry_q < 3'(MAX_RETRY)) begin
                        retry_d    = retry_q + 3'd1;
                        trim_req_d = 1'b1;
                        state_d    = ST_TRIM_REQ;
                    end else begin
                        bus_fail_d[index_q] = 1'b1;
                        end_trim_d          = 1'b1;
                        power_d             = 1'b0;
                        state_d             = ST_NEXT;
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
                ST_NEXT: if (index_q == last_idx) begin
                    state_d    = ST_DONE;
                    end_init_d = 1'b1;
                end else begin
                    index_d = index_q + BUS_W'(1);
                    state_d = ST_SELECT;
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            index_q      <= '0;
            retry_q      <= '0;
            bus_ok_q     <= '0;
            bus_fail_q   <= '0;
            busy_q       <= 1'b0;
            start_init_q <= 1'b0;
            end_init_q   <= 1'b0;
            power_q      <= 1'b0;
            trim_req_q   <= 1'b0;
            end_trim_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            retry_q      <= retry_d;
            bus_ok_q     <= bus_ok_d;
            bus_fail_q   <= bus_fail_d;
            busy_q       <= busy_d;
            start_init_q <= start_init_d;
            end_init_q   <= end_init_d;
            power_q      <= power_d;
            trim_req_q   <= trim_req_d;
            end_trim_q   <= end_trim_d;
        end
    end

    assign busy          = busy_q;
    assign start_init    = start_init_q;
    assign end_init      = end_init_q;
    assign power_bus_en  = power_q;
    assign power_bus_cnt = index_q;
    assign trim_req      = trim_req_q;
    assign end_trim_bus  = end_trim_q;
    assign bus_ok        = bus_ok_q;
    assign bus_fail      = bus_fail_q;

endmodule

// File: tb/tb_can_bus_init_seq.sv
// Directed bench for can_bus_init_seq: 8 buses, settle 4, timeout 16, 2 retries.
module tb_can_bus_init_seq;

    localparam int NB = 8;
    localparam int SETTLE = 4;
    localparam int TOUT = 16;

    logic clk = 1'b0;
    logic rst, start, abort;
    logic [2:0] n_buses;
    logic [NB-1:0] bus_mask;
    logic trim_ack = 1'b0;
    logic busy, start_init, end_init, power_bus_en, trim_req, end_trim_bus;
    logic [2:0] power_bus_cnt;
    logic [NB-1:0] bus_ok, bus_fail;

    can_bus_init_seq #(.N_BUSES(NB), .SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TOUT), .MAX_RETRY(2)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .n_buses(n_buses),
        .bus_mask(bus_mask), .trim_ack(trim_ack), .busy(busy), .start_init(start_init),
        .end_init(end_init), .power_bus_en(power_bus_en), .power_bus_cnt(power_bus_cnt),
        .trim_req(trim_req), .end_trim_bus(end_trim_bus), .bus_ok(bus_ok), .bus_fail(bus_fail)
    );

    always #5 clk = ~clk;

    // bus responder + event counters (sole writer of these variables)
    int cyc = 0, n_start = 0, n_end = 0, n_etrim = 0, n_req = 0, n_inv = 0;
    int n_gap = 0, n_gap_bad = 0, n_pwr_bad = 0;
    int req_bus [NB];
    int ack_cd = 0, attempt = 0, last_req = 0, pwr_run = 0;
    bit in_visit = 1'b0;
    // written only by the stimulus block
    int ack_on [NB];
    int ack_dly = 3;

    initial for (int i = 0; i < NB; i++) req_bus[i] = 0;

    always @(negedge clk) begin
        cyc++;
        trim_ack = 1'b0;
        if (ack_cd > 0) begin
            ack_cd--;
            if (ack_cd == 0) trim_ack = 1'b1;
        end
        if (start_init) n_start++;
        if (end_init) n_end++;
        if (end_trim_bus) n_etrim++;
        if ((bus_ok & bus_fail) != '0) n_inv++;
        if (trim_req) begin
            n_req++;
            req_bus[power_bus_cnt]++;
            if (in_visit) begin
                n_gap++;
                if (cyc - last_req != TOUT + 1) n_gap_bad++;
                attempt++;
            end else begin
                attempt = 1;
                if (pwr_run != SETTLE) n_pwr_bad++;
            end
            in_visit = 1'b1;
            last_req = cyc;
            if (ack_on[power_bus_cnt] == attempt) ack_cd = ack_dly;
        end
        if (end_trim_bus || !busy) in_visit = 1'b0;
        pwr_run = power_bus_en ? pwr_run + 1 : 0;
    end

    int checks = 0, errors = 0;
    int b_start, b_end, b_etrim, b_req, b_gap, b_pwr;
    int b_bus [NB];
    logic [4:0] nb31;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_start = n_start; b_end = n_end; b_etrim = n_etrim; b_req = n_req;
        b_gap = n_gap; b_pwr = n_pwr_bad;
        for (int i = 0; i < NB; i++) b_bus[i] = req_bus[i];
    endtask

    function automatic logic [NB-1:0] req_mask();
        logic [NB-1:0] m = '0;
        for (int i = 0; i < NB; i++) m[i] = (req_bus[i] != b_bus[i]);
        return m;
    endfunction

    task automatic set_ack(input int a0, input int a1, input int a2, input int rest);
        ack_on[0] = a0; ack_on[1] = a1; ack_on[2] = a2;
        for (int i = 3; i < NB; i++) ack_on[i] = rest;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 2000; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        chk(tag, busy, 0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0; n_buses = 3'd0; bus_mask = '0;
        set_ack(1, 1, 1, 1);
        repeat (3) @(negedge clk);
        chk("rst_ctl", {busy, start_init, end_init, power_bus_en, trim_req, end_trim_bus}, 0);
        chk("rst_cnt", power_bus_cnt, 0);
        chk("rst_flags", {bus_ok, bus_fail}, 0);
        rst = 1'b1;
        @(negedge clk);

        // 1: all pass on buses 0..3
        snap(); n_buses = 3'd3; bus_mask = 8'hFF; ack_dly = 3; set_ack(1, 1, 1, 1);
        pulse_start();
        chk("t1_start_init", {start_init, busy}, 2'b11);
        wait_idle("t1_idle");
        chk("t1_ok", bus_ok, 8'h0F);
        chk("t1_fail", bus_fail, 8'h00);
        chk("t1_etrim", n_etrim - b_etrim, 4);
        chk("t1_end_init", n_end - b_end, 1);
        chk("t1_req", n_req - b_req, 4);
        chk("t1_settle", n_pwr_bad - b_pwr, 0);
        chk("t1_last_idx", power_bus_cnt, 3);

        // 2: mask skip
        snap(); n_buses = 3'd7; bus_mask = 8'hA5;
        pulse_start();
        wait_idle("t2_idle");
        chk("t2_ok", bus_ok, 8'hA5);
        chk("t2_fail", bus_fail, 8'h00);
        chk("t2_req_mask", req_mask(), 8'hA5);
        chk("t2_req", n_req - b_req, 4);

        // 3: bus 1 passes on third attempt
        snap(); n_buses = 3'd1; bus_mask = 8'hFF; set_ack(1, 3, 1, 1);
        pulse_start();
        wait_idle("t3_idle");
        chk("t3_req_bus1", req_bus[1] - b_bus[1], 3);
        chk("t3_gaps", n_gap - b_gap, 2);
        chk("t3_ok", bus_ok, 8'h03);
        chk("t3_fail", bus_fail, 8'h00);

        // 4: bus 2 never acks
        snap(); n_buses = 3'd2; set_ack(1, 1, 0, 1);
        pulse_start();
        wait_idle("t4_idle");
        chk("t4_req_bus2", req_bus[2] - b_bus[2], 3);
        chk("t4_fail", bus_fail, 8'h04);
        chk("t4_ok", bus_ok, 8'h03);
        chk("t4_end_init", n_end - b_end, 1);
        chk("t4_etrim", n_etrim - b_etrim, 3);

        // 5: abort during bus 1 trim wait
        snap(); n_buses = 3'd3; set_ack(1, 0, 1, 1);
        pulse_start();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (trim_req && power_bus_cnt == 3'd1) break;
        end
        chk("t5_reached", {trim_req, power_bus_cnt}, 4'b1001);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("t5_abort", {busy, power_bus_en, trim_req}, 3'b000);
        repeat (3) @(negedge clk);
        chk("t5_no_end", n_end - b_end, 0);
        chk("t5_etrim", n_etrim - b_etrim, 1);
        chk("t5_ok", bus_ok, 8'h01);
        n_buses = 3'd0; set_ack(1, 1, 1, 1);
        pulse_start();
        chk("t5_clear", bus_ok, 8'h00);
        wait_idle("t5_idle");
        chk("t5_rerun", bus_ok, 8'h01);

        // 6a: out-of-range count clamps to the last bus
        nb31 = 5'd31;
        snap(); n_buses = nb31[2:0]; bus_mask = 8'h80;
        pulse_start();
        wait_idle("t6a_idle");
        chk("t6a_last_idx", power_bus_cnt, 7);
        chk("t6a_ok", bus_ok, 8'h80);

        // 6b: ack on the timeout cycle still passes
        snap(); n_buses = 3'd0; bus_mask = 8'h01; ack_dly = TOUT;
        pulse_start();
        wait_idle("t6b_idle");
        chk("t6b_ok", {bus_ok, bus_fail}, {8'h01, 8'h00});
        chk("t6b_req", n_req - b_req, 1);

        // 6c: start while busy ignored; start with abort in idle ignored
        snap(); ack_dly = 3;
        pulse_start();
        repeat (2) @(negedge clk);
        pulse_start();
        wait_idle("t6c_idle");
        chk("t6c_start_cnt", n_start - b_start, 1);
        chk("t6c_end_cnt", n_end - b_end, 1);
        snap();
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        chk("t6c_start_abort", {busy, start_init}, 2'b00);
        @(negedge clk);
        chk("t6c_start_cnt2", n_start - b_start, 0);

        chk("gap_17", n_gap_bad, 0);
        chk("ok_fail_excl", n_inv, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
